// File: rtl/extmem_pack_pkg.sv
// Shared types and sizing for the external-memory write packer.
package extmem_pack_pkg;

    localparam int DATA_W         = 16;
    localparam int WORDS_PER_BEAT = 4;
    localparam int ADDR_W         = 32;
    localparam int FIFO_DEPTH     = 8;
    localparam int TIMEOUT        = 16;

    localparam int LANE_W      = $clog2(WORDS_PER_BEAT);
    localparam int BEAT_ADDR_W = ADDR_W - LANE_W;
    localparam int BEAT_DATA_W = DATA_W * WORDS_PER_BEAT;

    typedef enum logic {
        EMPTY   = 1'b0,
        FILLING = 1'b1
    } pack_state_t;

    typedef struct packed {
        logic [BEAT_ADDR_W-1:0]    addr;
        logic [BEAT_DATA_W-1:0]    data;
        logic [WORDS_PER_BEAT-1:0] strb;
    } beat_t;

endpackage

// File: rtl/pack_beat_fifo.sv
// Beat FIFO between the packer and the memory bus; drops on push-while-full
// (unless a pop frees the slot in the same cycle) and flags it stickily.
module pack_beat_fifo
    import extmem_pack_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  beat_t push_beat,
    input  logic  pop,
    output beat_t head,
    output logic  full,
    output logic  empty,
    output logic  overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    beat_t            r_mem [FIFO_DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             r_overflow;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign overflow  = r_overflow;

    // Head is forced to zero when empty so the bus idles at all-zero.
    assign head = empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr[PTR_W-1:0]] <= push_beat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (push && !w_do_push)
                r_overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/extmem_write_packer.sv
// Coalesces consecutive word writes into strobed beats and drains them over valid/ready.
// Optional idle auto-flush: define EXTMEM_PACK_TIMEOUT_EN.
module extmem_write_packer
    import extmem_pack_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_we,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      flush,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [BEAT_ADDR_W-1:0]    mem_addr,
    output logic [BEAT_DATA_W-1:0]    mem_data,
    output logic [WORDS_PER_BEAT-1:0] mem_strb,
    output logic                      idle,
    output logic                      overflow
);

    pack_state_t               r_state, w_state_nxt;
    logic [BEAT_ADDR_W-1:0]    r_pack_addr, w_pack_addr_nxt;
    logic [BEAT_DATA_W-1:0]    r_pack_data, w_pack_data_nxt;
    logic [WORDS_PER_BEAT-1:0] r_pack_mask, w_pack_mask_nxt;
    logic                      r_flush_pending, w_flush_pending_nxt;

    logic [LANE_W-1:0]         w_lane;
    logic [BEAT_ADDR_W-1:0]    w_beat;
    logic [WORDS_PER_BEAT-1:0] w_lane_onehot;
    logic [BEAT_DATA_W-1:0]    w_merged_data;
    logic [BEAT_DATA_W-1:0]    w_fresh_data;
    logic [WORDS_PER_BEAT-1:0] w_merged_mask;
    logic                      w_flush_eff;
    logic                      w_timeout;
    logic                      w_push;
    beat_t                     w_push_beat;
    beat_t                     w_head;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;

    assign w_lane        = in_addr[LANE_W-1:0];
    assign w_beat        = in_addr[ADDR_W-1:LANE_W];
    assign w_lane_onehot = {{(WORDS_PER_BEAT-1){1'b0}}, 1'b1} << w_lane;
    assign w_merged_mask = r_pack_mask | w_lane_onehot;

    always_comb begin
        w_merged_data = r_pack_data;
        w_fresh_data  = '0;
        for (int i = 0; i < WORDS_PER_BEAT; i++) begin
            if (w_lane == LANE_W'(i)) begin
                w_merged_data[i*DATA_W +: DATA_W] = in_data;
                w_fresh_data[i*DATA_W +: DATA_W]  = in_data;
            end
        end
    end

`ifdef EXTMEM_PACK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tmo_cnt <= '0;
        else if (in_we)
            r_tmo_cnt <= TMO_W'(TIMEOUT);
        else if (r_state == FILLING && r_tmo_cnt != '0)
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
    end

    // Fires in the last of TIMEOUT write-free cycles, so the push lands TIMEOUT edges after the write.
    assign w_timeout = (r_state == FILLING) && !in_we && (r_tmo_cnt == TMO_W'(1));
`else
    assign w_timeout = 1'b0;
`endif

    // A pending flush from a beat-change-plus-flush cycle acts like a fresh flush pulse.
    assign w_flush_eff = flush || r_flush_pending || w_timeout;

    always_comb begin
        w_state_nxt         = r_state;
        w_pack_addr_nxt     = r_pack_addr;
        w_pack_data_nxt     = r_pack_data;
        w_pack_mask_nxt     = r_pack_mask;
        w_flush_pending_nxt = 1'b0;
        w_push              = 1'b0;
        w_push_beat         = '{addr: r_pack_addr, data: r_pack_data, strb: r_pack_mask};
        case (r_state)
            EMPTY: begin
                if (in_we) begin
                    w_pack_addr_nxt = w_beat;
                    w_pack_data_nxt = w_fresh_data;
                    w_pack_mask_nxt = w_lane_onehot;
                    w_state_nxt     = FILLING;
                end
            end
            FILLING: begin
                if (in_we && w_beat == r_pack_addr) begin
                    w_pack_data_nxt = w_merged_data;
                    w_pack_mask_nxt = w_merged_mask;
                    if (&w_merged_mask || w_flush_eff) begin
                        w_push          = 1'b1;
                        w_push_beat     = '{addr: r_pack_addr, data: w_merged_data, strb: w_merged_mask};
                        w_pack_mask_nxt = '0;
                        w_state_nxt     = EMPTY;
                    end
                end else if (in_we) begin
                    w_push              = 1'b1;
                    w_pack_addr_nxt     = w_beat;
                    w_pack_data_nxt     = w_fresh_data;
                    w_pack_mask_nxt     = w_lane_onehot;
                    w_flush_pending_nxt = w_flush_eff;
                end else if (w_flush_eff) begin
                    w_push          = 1'b1;
                    w_pack_mask_nxt = '0;
                    w_state_nxt     = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= EMPTY;
            r_pack_addr     <= '0;
            r_pack_data     <= '0;
            r_pack_mask     <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pack_addr     <= w_pack_addr_nxt;
            r_pack_data     <= w_pack_data_nxt;
            r_pack_mask     <= w_pack_mask_nxt;
            r_flush_pending <= w_flush_pending_nxt;
        end
    end

    pack_beat_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_beat (w_push_beat),
        .pop       (mem_ready),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .overflow  (overflow)
    );

    assign mem_valid = !w_fifo_empty;
    assign mem_addr  = w_head.addr;
    assign mem_data  = w_head.data;
    assign mem_strb  = w_head.strb;
    assign idle      = (r_state == EMPTY) && w_fifo_empty && !r_flush_pending;

endmodule
